// File: rtl/core_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// core_sequencer
//
// Multicycle control sequencer for the RV32I core. Steps each instruction
// through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and issues the PC,
// instruction-register, memory and register-file strobes. Counts retired
// instructions (one per PC load).
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   : memory waits in FETCH/MEMORY are bounded by TIMEOUT_CYCLES;
//               on expiry the sequencer halts and raises SEQ_Timeout.
//   undefined : waits are unbounded and SEQ_Timeout is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  wait cycles allowed before timeout (SEQ_TIMEOUT_EN only)
//   RET_WIDTH       width of the retired-instruction counter
//
// Ports
//   SEQ_Clk           in   core clock, rising edge
//   SEQ_Reset         in   synchronous active-high reset
//   SEQ_En            in   run enable; low freezes state and drops strobes
//   SEQ_Opcode[6:0]   in   IR[6:0], valid from DECODE onward
//   SEQ_Mem_Ready     in   memory handshake (sampled in FETCH and MEMORY)
//   SEQ_Branch_Taken  in   ALU compare result, valid in EXECUTE
//   SEQ_PC_Set_En     out  one-cycle PC load strobe
//   SEQ_PC_Sel[1:0]   out  00 PC+4, 01 PC+imm, 10 rs1+imm
//   SEQ_IR_Load       out  instruction-register load strobe
//   SEQ_Mem_Req       out  memory request
//   SEQ_Mem_We        out  write qualifier for SEQ_Mem_Req
//   SEQ_RF_We         out  register-file write strobe
//   SEQ_State[2:0]    out  0 FETCH 1 DECODE 2 EXECUTE 3 MEMORY 4 WRITEBACK 5 HALT
//   SEQ_Illegal       out  sticky: unsupported opcode decoded
//   SEQ_Timeout       out  sticky: memory wait limit exceeded
//   SEQ_Retired       out  retired-instruction count (wraps silently)
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RET_WIDTH      = 32
) (
  input  logic                 SEQ_Clk,
  input  logic                 SEQ_Reset,
  input  logic                 SEQ_En,
  input  logic [6:0]           SEQ_Opcode,
  input  logic                 SEQ_Mem_Ready,
  input  logic                 SEQ_Branch_Taken,
  output logic                 SEQ_PC_Set_En,
  output logic [1:0]           SEQ_PC_Sel,
  output logic                 SEQ_IR_Load,
  output logic                 SEQ_Mem_Req,
  output logic                 SEQ_Mem_We,
  output logic                 SEQ_RF_We,
  output logic [2:0]           SEQ_State,
  output logic                 SEQ_Illegal,
  output logic                 SEQ_Timeout,
  output logic [RET_WIDTH-1:0] SEQ_Retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  if (TIMEOUT_CYCLES < 1 || RET_WIDTH < 1) begin : g_bad_params
    $error("core_sequencer: TIMEOUT_CYCLES and RET_WIDTH must be >= 1");
  end

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_illegal;
  logic [RET_WIDTH-1:0]   r_retired;
  logic                   w_active;
  logic                   w_waiting;
  logic                   w_legal;
  logic                   w_wait_expire;

  // Strobes only exist while running and out of reset.
  assign w_active  = !SEQ_Reset && SEQ_En;
  assign w_waiting = (r_state == S_FETCH || r_state == S_MEMORY) && !SEQ_Mem_Ready;

  always_comb begin
    case (SEQ_Opcode)
      OP_LOAD, OP_STORE, OP_ALU, OP_ALUI, OP_LUI,
      OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR, OP_FENCE: w_legal = 1'b1;
      default:                                         w_legal = 1'b0;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;

  // Expires on the TIMEOUT_CYCLES-th consecutive wait cycle; a Ready in that
  // same cycle is not a wait cycle, so Ready wins.
  assign w_wait_expire = w_active && w_waiting &&
                         (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge SEQ_Clk) begin
    if (SEQ_Reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_active) begin
      // Counter clears whenever the state changes (Ready, expiry, or a
      // non-waiting state) and holds while SEQ_En is low.
      if (w_waiting && !w_wait_expire) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                             r_wait_cnt <= '0;
      if (w_wait_expire) r_timeout <= 1'b1;
    end
  end

  assign SEQ_Timeout = r_timeout;
`else
  assign w_wait_expire = 1'b0;
  assign SEQ_Timeout   = 1'b0;
`endif

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    w_next_state  = r_state;
    SEQ_PC_Set_En = 1'b0;
    SEQ_PC_Sel    = 2'b00;
    SEQ_IR_Load   = 1'b0;
    SEQ_Mem_Req   = 1'b0;
    SEQ_Mem_We    = 1'b0;
    SEQ_RF_We     = 1'b0;
    if (w_active) begin
      case (r_state)
        S_FETCH: begin
          SEQ_Mem_Req = 1'b1;
          if (SEQ_Mem_Ready) begin
            SEQ_IR_Load  = 1'b1;
            w_next_state = S_DECODE;
          end else if (w_wait_expire) begin
            w_next_state = S_HALT;
          end
        end
        S_DECODE: w_next_state = w_legal ? S_EXECUTE : S_HALT;
        S_EXECUTE: begin
          case (SEQ_Opcode)
            OP_LOAD, OP_STORE: w_next_state = S_MEMORY;
            OP_BRANCH: begin
              SEQ_PC_Set_En = 1'b1;
              SEQ_PC_Sel    = SEQ_Branch_Taken ? 2'b01 : 2'b00;
              w_next_state  = S_FETCH;
            end
            OP_FENCE: begin
              SEQ_PC_Set_En = 1'b1;
              w_next_state  = S_FETCH;
            end
            default: w_next_state = S_WRITEBACK;
          endcase
        end
        S_MEMORY: begin
          SEQ_Mem_Req = 1'b1;
          SEQ_Mem_We  = (SEQ_Opcode == OP_STORE);
          if (SEQ_Mem_Ready) begin
            if (SEQ_Opcode == OP_STORE) begin
              SEQ_PC_Set_En = 1'b1;
              w_next_state  = S_FETCH;
            end else begin
              w_next_state  = S_WRITEBACK;
            end
          end else if (w_wait_expire) begin
            w_next_state = S_HALT;
          end
        end
        S_WRITEBACK: begin
          SEQ_RF_We     = 1'b1;
          SEQ_PC_Set_En = 1'b1;
          if (SEQ_Opcode == OP_JAL)       SEQ_PC_Sel = 2'b01;
          else if (SEQ_Opcode == OP_JALR) SEQ_PC_Sel = 2'b10;
          w_next_state = S_FETCH;
        end
        S_HALT:  w_next_state = S_HALT;
        default: w_next_state = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge SEQ_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (SEQ_Reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_active && r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
      // Strobe is already gated by reset/enable; wraps with no flag.
      if (SEQ_PC_Set_En) r_retired <= r_retired + RET_WIDTH'(1);
    end
  end

  assign SEQ_State   = r_state;
  assign SEQ_Illegal = r_illegal;
  assign SEQ_Retired = r_retired;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multicycle control sequencer for the RV32I core. Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and issues the program-counter set-enable, PC source select, instruction-register load, memory request and register-file write strobes. Sits between the instruction register/decoder and the PC, memory interface and register file, and replaces free-running PC enable generation with per-instruction sequencing. Also keeps a retired-instruction counter.

## Interface
- TIMEOUT_CYCLES, 16: maximum wait cycles on SEQ_Mem_Ready before a timeout (used only with SEQ_TIMEOUT_EN).
- RET_WIDTH, 32: width of the retired-instruction counter.

- SEQ_Clk  in  1  core clock; all state updates on the rising edge.
- SEQ_Reset  in  1  synchronous, active-high reset.
- SEQ_En  in  1  run enable; low freezes the sequencer.
- SEQ_Opcode  in  7  IR[6:0]; valid from DECODE onward.
- SEQ_Mem_Ready  in  1  memory handshake; completes the current request.
- SEQ_Branch_Taken  in  1  ALU compare result, valid in EXECUTE.
- SEQ_PC_Set_En  out  1  one-cycle PC load strobe.
- SEQ_PC_Sel  out  2  PC source: 00 = PC+4, 01 = PC+imm, 10 = rs1+imm (JALR).
- SEQ_IR_Load  out  1  instruction-register load strobe.
- SEQ_Mem_Req  out  1  memory request.
- SEQ_Mem_We  out  1  write qualifier for SEQ_Mem_Req.
- SEQ_RF_We  out  1  register-file write strobe.
- SEQ_State  out  3  current state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK, 5 HALT.
- SEQ_Illegal  out  1  sticky flag; unsupported opcode reached.
- SEQ_Timeout  out  1  sticky flag; memory wait exceeded the limit.
- SEQ_Retired  out  RET_WIDTH  count of completed instructions.

## Operation
- The state register is the only FSM storage. Strobes are decoded combinationally from the state, SEQ_Opcode, SEQ_Mem_Ready and SEQ_Branch_Taken.
- All strobes are forced to 0 while SEQ_Reset = 1 or SEQ_En = 0.
- Reset values:
  - state = FETCH
  - SEQ_Retired = 0
  - SEQ_Illegal = 0
  - SEQ_Timeout = 0
  - wait counter = 0
  - all strobes = 0
- FETCH:
  - Drives SEQ_Mem_Req=1 and SEQ_Mem_We=0.
  - Holds until SEQ_Mem_Ready=1. In that cycle it drives SEQ_IR_Load=1, then moves to DECODE.
- DECODE: always moves to EXECUTE. Opcode classification happens in this state.
  - An unsupported opcode moves to HALT instead and sets SEQ_Illegal.
  - Supported opcodes: 0000011, 0100011, 0110011, 0010011, 0110111, 0010111, 1100011, 1101111, 1100111, 0001111.
- EXECUTE:
  - LOAD (0000011) and STORE (0100011) go to MEMORY.
  - BRANCH (1100011): drives SEQ_PC_Set_En=1 with SEQ_PC_Sel = 01 if taken, else 00; goes to FETCH.
  - FENCE (0001111): treated as a NOP; drives SEQ_PC_Set_En=1 with SEQ_PC_Sel=00; goes to FETCH.
  - All other supported opcodes go to WRITEBACK.
- MEMORY:
  - Drives SEQ_Mem_Req=1, with SEQ_Mem_We=1 for STORE and 0 for LOAD. Holds until SEQ_Mem_Ready=1.
  - On ready, LOAD goes to WRITEBACK.
  - On ready, STORE drives SEQ_PC_Set_En=1 with SEQ_PC_Sel=00 and goes to FETCH.
- WRITEBACK: drives SEQ_RF_We=1 and SEQ_PC_Set_En=1 for exactly one cycle, then goes to FETCH.
  - SEQ_PC_Sel = 01 for JAL, 10 for JALR, 00 otherwise.
- HALT: all strobes are 0. Exited only by reset.
- SEQ_Retired increments by 1 on every cycle with SEQ_PC_Set_En=1. It wraps from 2^RET_WIDTH−1 to 0 with no flag.
- SEQ_En=0:
  - State, counters and flags hold; Mem_Req drops.
  - A pending FETCH or MEMORY request is re-issued when SEQ_En returns. The memory side must discard an unacknowledged request whose Mem_Req dropped.
- Reset mid-instruction: the instruction is abandoned, the next state is FETCH, and SEQ_PC_Set_En is not pulsed. Reset has priority over SEQ_En and all other inputs.

## Timing
- Minimum latency, from entering FETCH to the PC_Set_En pulse, with zero-wait memory:
  - BRANCH and FENCE: 3 cycles.
  - ALU, LUI, AUIPC, JAL and JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- SEQ_Mem_Ready is sampled only in FETCH and MEMORY and ignored elsewhere.
- Simultaneous events:
  - If Ready arrives on the same edge the timeout would fire, Ready wins.
  - SEQ_PC_Set_En and SEQ_RF_We never assert outside the states listed under Operation.
- SEQ_Retired and SEQ_State reflect the registered value, one cycle after the causing strobe.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A wait counter runs in FETCH and MEMORY while SEQ_Mem_Ready=0 and SEQ_En=1. It clears on state change.
  - When the counter reaches TIMEOUT_CYCLES, the next state is HALT and SEQ_Timeout is set (sticky).
- SEQ_TIMEOUT_EN undefined: no wait counter, waits are unbounded, and SEQ_Timeout is tied to 0.

## Test plan
- Reset held 2 cycles, then released; SEQ_En=1; ALU opcode 0110011; Ready always 1.
  - Expect states 0,1,2,4,0.
  - Expect IR_Load in cycle 1, RF_We and PC_Set_En with Sel=00 in cycle 4.
  - Expect SEQ_Retired=1.
- BRANCH 1100011 with Branch_Taken=1, then Branch_Taken=0.
  - Expect PC_Set_En in EXECUTE with Sel=01, then Sel=00.
  - Expect no RF_We; SEQ_Retired=2.
- LOAD with Ready held low 3 cycles in MEMORY.
  - Expect Mem_Req=1 and Mem_We=0 for 4 cycles.
  - Expect WRITEBACK next, total latency 8 cycles.
  - Then STORE: expect Mem_We=1 in MEMORY and PC_Set_En on Ready.
- Opcode 1111111 in DECODE.
  - Expect state 5 and SEQ_Illegal=1, with no strobes for 10 cycles.
  - Then reset: expect state 0 and Illegal=0.
- JALR with SEQ_En dropped for 2 cycles in EXECUTE, then reset asserted in WRITEBACK.
  - Expect state held during the SEQ_En drop.
  - Expect no PC_Set_En in the reset cycle, then FETCH.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=4, Ready held 0 in FETCH: expect HALT and SEQ_Timeout=1 after 4 wait cycles.
  - Without the macro: expect FETCH held for 100 cycles.
